stream_multiplexer: RTL and testbench

Parametrised N-to-1 stream multiplexer with valid/ready handshakes, packet-aware arbitration and a registered output stage. It is the successor to the combinational 2:1 multiplexer. Instead of a static select input, it arbitrates between CHANNELS requesters and holds the grant for the whole of a multi-beat packet. It feeds a single downstream consumer and reports which channel each beat came from.

---
 rtl/stream_multiplexer_pkg.sv | 31 +++
 rtl/stream_multiplexer_round_robin_arbiter.sv | 39 +++
 rtl/stream_multiplexer.sv | 121 ++++++++++++
 tb/tb_stream_multiplexer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_multiplexer_pkg.sv
// Shared definitions for the stream multiplexer: arbitration mode codes,
// FSM state encoding and the select-width helpers.
package stream_multiplexer_pkg;

    localparam int MUX_MODE_ROUND_ROBIN = 0;
    localparam int MUX_MODE_FIXED       = 1;

    typedef enum logic {
        STATE_IDLE   = 1'b0,
        STATE_LOCKED = 1'b1
    } mux_state_t;

    // Ceiling log2; clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        return result;
    endfunction

    // Channel index width, never narrower than one bit so CHANNELS=1 still elaborates.
    function automatic int sel_width(input int channels);
        return (clog2(channels) < 1) ? 1 : clog2(channels);
    endfunction

endpackage

// File: rtl/stream_multiplexer_round_robin_arbiter.sv
// Combinational arbiter: picks one requester, either scanning upward from
// pointer with wrap (round-robin) or always from index 0 (fixed priority).
module round_robin_arbiter
    import stream_multiplexer_pkg::*;
#(
    parameter  int CHANNELS  = 4,
    parameter  int MODE      = MUX_MODE_ROUND_ROBIN,
    localparam int SEL_WIDTH = sel_width(CHANNELS)
) (
    input  logic [CHANNELS-1:0]  request,
    input  logic [SEL_WIDTH-1:0] pointer,
    output logic [CHANNELS-1:0]  grant,
    output logic [SEL_WIDTH-1:0] grant_idx
);

    // First requester found from the scan start wins; grant stays zero with no requests.
    always_comb begin : arbitrate
        int   start;
        int   idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        start     = (MODE == MUX_MODE_ROUND_ROBIN) ? int'(pointer) : 0;
        for (int i = 0; i < CHANNELS; i++) begin
            idx = start + i;
            if (idx >= CHANNELS) begin
                idx = idx - CHANNELS;
            end
            if (!found && request[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = SEL_WIDTH'(idx);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_multiplexer.sv
// N-to-1 packet-aware stream multiplexer. Arbitrates between channels, holds
// the grant for the whole of a multi-beat packet and registers the output beat
// together with the channel it came from.
module stream_multiplexer
    import stream_multiplexer_pkg::*;
#(
    parameter  int CHANNELS   = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int MODE       = MUX_MODE_ROUND_ROBIN,
    localparam int SEL_WIDTH  = sel_width(CHANNELS)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [CHANNELS-1:0]            in_valid,
    input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]            in_last,
    output logic [CHANNELS-1:0]            in_ready,
    output logic                           out_valid,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic                           out_last,
    output logic [SEL_WIDTH-1:0]           out_channel,
    input  logic                           out_ready
);

    mux_state_t             state;
    logic [SEL_WIDTH-1:0]   pointer;
    logic [SEL_WIDTH-1:0]   lock_ch;
    logic [SEL_WIDTH-1:0]   next_pointer;

    logic [CHANNELS-1:0]    arb_grant;
    logic [SEL_WIDTH-1:0]   arb_idx;
    logic [CHANNELS-1:0]    lock_grant;
    logic [CHANNELS-1:0]    grant;
    logic [SEL_WIDTH-1:0]   grant_idx;

    logic                   adv;
    logic                   accept;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic                   sel_last;

    round_robin_arbiter #(
        .CHANNELS (CHANNELS),
        .MODE     (MODE)
    ) u_arbiter (
        .request   (in_valid),
        .pointer   (pointer),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    // One-hot form of the locked channel, used while a packet is in flight.
    always_comb begin
        lock_grant = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            lock_grant[k] = (lock_ch == SEL_WIDTH'(k));
        end
    end

    assign grant     = (state == STATE_LOCKED) ? lock_grant : arb_grant;
    assign grant_idx = (state == STATE_LOCKED) ? lock_ch    : arb_idx;

    // The output register can take a new beat when empty or being drained.
    assign adv      = !out_valid || out_ready;
    assign in_ready = (adv && !reset) ? (grant & in_valid) : '0;
    assign accept   = |in_ready;

    // Payload and last flag of the granted channel (grant is one-hot or zero).
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (grant[k]) begin
                sel_data = sel_data | in_data[k*DATA_WIDTH +: DATA_WIDTH];
                sel_last = sel_last | in_last[k];
            end
        end
    end

    assign next_pointer = (grant_idx == SEL_WIDTH'(CHANNELS - 1)) ? '0
                                                                  : grant_idx + SEL_WIDTH'(1);

    // Packet FSM: lock onto a channel after a non-last beat, release on its last
    // beat; round-robin pointer moves past the channel that just finished.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= STATE_IDLE;
            lock_ch <= '0;
            pointer <= '0;
        end else if (accept) begin
            if (state == STATE_IDLE) begin
                if (!sel_last) begin
                    state   <= STATE_LOCKED;
                    lock_ch <= grant_idx;
                end
            end else if (sel_last) begin
                state <= STATE_IDLE;
            end
            if (sel_last && (MODE == MUX_MODE_ROUND_ROBIN)) begin
                pointer <= next_pointer;
            end
        end
    end

    // Output stage: load on acceptance, empty when drained with nothing new.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            out_channel <= '0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_data    <= sel_data;
            out_last    <= sel_last;
            out_channel <= grant_idx;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_multiplexer.sv
// Bench for stream_multiplexer: a round-robin and a fixed-priority instance
// share one stimulus; a packet-level model predicts both every cycle, and
// directed steps pin hand-computed values.
module tb_stream_multiplexer;

    localparam int CH = 4;
    localparam int DW = 8;

    logic              clock;
    logic              reset;
    logic [CH-1:0]     in_valid;
    logic [CH-1:0]     in_last;
    logic [CH*DW-1:0]  in_data;
    logic              out_ready;

    logic [CH-1:0]     dut_in_ready    [2];
    logic              dut_out_valid   [2];
    logic [DW-1:0]     dut_out_data    [2];
    logic              dut_out_last    [2];
    logic [1:0]        dut_out_channel [2];

    int vectors     = 0;
    int miscompares = 0;
    bit compare_on  = 1'b0;

    stream_multiplexer #(.CHANNELS(CH), .DATA_WIDTH(DW), .MODE(0)) dut_rr (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_ready    (dut_in_ready[0]),
        .out_valid   (dut_out_valid[0]),
        .out_data    (dut_out_data[0]),
        .out_last    (dut_out_last[0]),
        .out_channel (dut_out_channel[0]),
        .out_ready   (out_ready)
    );

    stream_multiplexer #(.CHANNELS(CH), .DATA_WIDTH(DW), .MODE(1)) dut_fp (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_ready    (dut_in_ready[1]),
        .out_valid   (dut_out_valid[1]),
        .out_data    (dut_out_data[1]),
        .out_last    (dut_out_last[1]),
        .out_channel (dut_out_channel[1]),
        .out_ready   (out_ready)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet-level model, index 0 = round-robin, 1 = fixed priority.
    // owner = channel whose packet is open (-1 none); turn = next channel to favour.
    int            m_owner [2];
    int            m_turn  [2];
    bit            m_valid [2];
    logic [DW-1:0] m_data  [2];
    bit            m_last  [2];
    int            m_ch    [2];

    function automatic int exp_grant(input int m);
        int c;
        if (m_owner[m] >= 0) begin
            return in_valid[m_owner[m]] ? m_owner[m] : -1;
        end
        for (int i = 0; i < CH; i++) begin
            c = (m == 0) ? (m_turn[m] + i) % CH : i;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic bit model_adv(input int m);
        return !m_valid[m] || out_ready;
    endfunction

    function automatic logic [DW-1:0] beat_data(input int c);
        return in_data[c*DW +: DW];
    endfunction

    function automatic logic [CH-1:0] exp_ready(input int m);
        if (reset || !model_adv(m) || exp_grant(m) < 0) return '0;
        return 4'b0001 << exp_grant(m);
    endfunction

    always @(posedge clock or posedge reset) begin
        for (int m = 0; m < 2; m++) begin
            if (reset) begin
                m_owner[m] <= -1;
                m_turn[m]  <= 0;
                m_valid[m] <= 1'b0;
                m_data[m]  <= '0;
                m_last[m]  <= 1'b0;
                m_ch[m]    <= 0;
            end else if (model_adv(m) && exp_grant(m) >= 0) begin
                m_valid[m] <= 1'b1;
                m_data[m]  <= beat_data(exp_grant(m));
                m_last[m]  <= in_last[exp_grant(m)];
                m_ch[m]    <= exp_grant(m);
                if (in_last[exp_grant(m)]) begin
                    m_owner[m] <= -1;
                    if (m == 0) m_turn[m] <= (exp_grant(m) + 1) % CH;
                end else begin
                    m_owner[m] <= exp_grant(m);
                end
            end else if (out_ready) begin
                m_valid[m] <= 1'b0;
            end
        end
    end

    // Mid-cycle comparison of both instances against the model.
    always @(negedge clock) begin
        if (compare_on) begin
            for (int m = 0; m < 2; m++) begin
                chk($sformatf("in_ready[m%0d]", m),    32'(dut_in_ready[m]),    32'(exp_ready(m)));
                chk($sformatf("out_valid[m%0d]", m),   32'(dut_out_valid[m]),   32'(m_valid[m]));
                chk($sformatf("out_data[m%0d]", m),    32'(dut_out_data[m]),    32'(m_data[m]));
                chk($sformatf("out_last[m%0d]", m),    32'(dut_out_last[m]),    32'(m_last[m]));
                chk($sformatf("out_channel[m%0d]", m), 32'(dut_out_channel[m]), 32'(m_ch[m]));
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset();
        #1 reset = 1'b1;
        #1 reset = 1'b0;
    endtask

    task automatic set_ch(input int k, input logic [DW-1:0] d, input logic l, input logic v);
        in_data[k*DW +: DW] = d;
        in_last[k]          = l;
        in_valid[k]         = v;
    endtask

    task automatic idle_inputs();
        in_valid = '0;
        in_last  = '0;
        in_data  = '0;
    endtask

    initial begin
        // Reset with every input high
        reset     = 1'b1;
        out_ready = 1'b1;
        in_valid  = '1;
        in_last   = '1;
        in_data   = '1;
        step();
        compare_on = 1'b1;
        step();
        for (int m = 0; m < 2; m++) begin
            chk("rst_out_valid",   32'(dut_out_valid[m]),   32'h0);
            chk("rst_out_data",    32'(dut_out_data[m]),    32'h0);
            chk("rst_out_channel", 32'(dut_out_channel[m]), 32'h0);
            chk("rst_in_ready",    32'(dut_in_ready[m]),    32'h0);
        end
        reset = 1'b0;
        idle_inputs();
        set_ch(2, 8'hA5, 1'b1, 1'b1);
        step();
        chk("first_valid",   32'(dut_out_valid[0]),   32'h1);
        chk("first_data",    32'(dut_out_data[0]),    32'hA5);
        chk("first_channel", 32'(dut_out_channel[0]), 32'h2);
        idle_inputs();
        step();

        // Round-robin over four always-valid single-beat channels
        pulse_reset();
        for (int k = 0; k < CH; k++) set_ch(k, DW'(16 + k), 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rr_seq_channel", 32'(dut_out_channel[0]), 32'(i % 4));
            chk("rr_seq_data",    32'(dut_out_data[0]),    32'(16 + i % 4));
        end
        idle_inputs();
        step();

        // Packet lock on ch1 with ch0/ch3 competing
        pulse_reset();
        set_ch(0, 8'h20, 1'b1, 1'b1);
        step();
        chk("lock_pre_channel", 32'(dut_out_channel[0]), 32'h0);
        set_ch(1, 8'hB1, 1'b0, 1'b1);
        set_ch(3, 8'h33, 1'b1, 1'b1);
        step();
        chk("lock_b1_channel", 32'(dut_out_channel[0]), 32'h1);
        chk("lock_b1_data",    32'(dut_out_data[0]),    32'hB1);
        set_ch(1, 8'hB2, 1'b0, 1'b1);
        #1;
        chk("lock_in_ready", 32'(dut_in_ready[0]), 32'h2);
        step();
        chk("lock_b2_data", 32'(dut_out_data[0]), 32'hB2);
        set_ch(1, 8'hB3, 1'b1, 1'b1);
        step();
        chk("lock_b3_data", 32'(dut_out_data[0]), 32'hB3);
        chk("lock_b3_last", 32'(dut_out_last[0]), 32'h1);
        set_ch(1, 8'h00, 1'b0, 1'b0);
        step();
        chk("lock_next_channel", 32'(dut_out_channel[0]), 32'h3);
        chk("lock_next_data",    32'(dut_out_data[0]),    32'h33);

        // Back-pressure holds the ch3 beat for five cycles
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_data",     32'(dut_out_data[0]),  32'h33);
            chk("bp_valid",    32'(dut_out_valid[0]), 32'h1);
            chk("bp_in_ready", 32'(dut_in_ready[0]),  32'h0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(dut_in_ready[0]), 32'h1);
        step();
        chk("bp_follow_channel", 32'(dut_out_channel[0]), 32'h0);
        chk("bp_follow_data",    32'(dut_out_data[0]),    32'h20);
        idle_inputs();
        step();

        // Fixed priority: ch0 starves ch3 until it drops
        pulse_reset();
        set_ch(0, 8'h40, 1'b1, 1'b1);
        set_ch(3, 8'h43, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("fp_channel",  32'(dut_out_channel[1]), 32'h0);
            chk("fp_data",     32'(dut_out_data[1]),    32'h40);
            chk("fp_in_ready", 32'(dut_in_ready[1]),    32'h1);
        end
        set_ch(0, 8'h40, 1'b1, 1'b0);
        #1;
        chk("fp_drop_ready", 32'(dut_in_ready[1]), 32'h8);
        step();
        chk("fp_drop_channel", 32'(dut_out_channel[1]), 32'h3);
        chk("fp_drop_data",    32'(dut_out_data[1]),    32'h43);
        idle_inputs();
        step();

        // Asynchronous reset in the middle of a ch2 packet
        pulse_reset();
        set_ch(2, 8'h60, 1'b0, 1'b1);
        step();
        chk("mid_channel", 32'(dut_out_channel[0]), 32'h2);
        set_ch(0, 8'h50, 1'b1, 1'b1);
        #1;
        chk("mid_lock_ready", 32'(dut_in_ready[0]), 32'h4);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_valid_rr", 32'(dut_out_valid[0]), 32'h0);
        chk("mid_rst_data_rr",  32'(dut_out_data[0]),  32'h0);
        chk("mid_rst_valid_fp", 32'(dut_out_valid[1]), 32'h0);
        reset = 1'b0;
        step();
        chk("post_rst_channel", 32'(dut_out_channel[0]), 32'h0);
        chk("post_rst_data",    32'(dut_out_data[0]),    32'h50);
        idle_inputs();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
